// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scan_ctrl
//  Description : LED-matrix scan controller. Fetches one 16-pixel row from a
//                double-buffered frame store, shifts 16 anode bits and
//                16 cathode bits to an external shift-register chain, then
//                latches them. Front/back buffer swaps happen only at frame
//                boundaries.
//  Options     : define MATRIX_GRAY_EN for 4-phase grayscale (64-row frames).
//                Without it, phase is fixed at 0 and a frame is 16 rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl #(
  parameter int CLK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_rd_req,
  output logic [3:0]  pix_rd_row,
  output logic        pix_rd_sel,
  input  logic        pix_rd_ack,
  input  logic [31:0] pix_rd_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        front_sel,
  output logic        frame_start,
  output logic        sclk,
  output logic        serial_data,
  output logic        rclk,
  output logic        clear
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [9:0] C_DIV_LAST  = 10'(CLK_DIV - 1);
  // 32 bits x 2 half-bits, plus one final tick that hands over to LATCH
  localparam logic [6:0] C_STEP_LAST = 7'd64;

  state_t      state_q;
  logic [9:0]  div_q;
  logic [6:0]  step_q;
  logic        latch_q;
  logic [3:0]  row_q;
  logic [31:0] data_q;
  logic        started_q;
  logic        req_q;
  logic        front_sel_q;
  logic        swap_ack_q;
  logic        frame_start_q;
  logic        sclk_q;
  logic        sdata_q;
  logic        rclk_q;
  logic        clear_q;

  logic        w_tick;
  logic        w_row_done;
  logic        w_frame_end;
  logic [1:0]  w_phase;
  logic [4:0]  w_bit_idx;
  logic [3:0]  w_pix_col;
  logic [1:0]  w_pix;
  logic        w_bit_val;

  assign w_tick     = (div_q == C_DIV_LAST);
  assign w_row_done = (state_q == ST_LATCH) && w_tick && latch_q;

`ifdef MATRIX_GRAY_EN
  logic [1:0] phase_q;

  // Grayscale phase advances once per complete pass over all 16 rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
    end else if (w_row_done && (row_q == 4'd15)) begin
      phase_q <= phase_q + 2'd1;
    end
  end

  assign w_phase     = phase_q;
  assign w_frame_end = (row_q == 4'd15) && (phase_q == 2'd3);
`else
  assign w_phase     = 2'd0;
  assign w_frame_end = (row_q == 4'd15);
`endif

  // Bit order: bits 0..15 are anodes for pixel 15 down to 0, bits 16..31
  // are cathodes where only the active row is driven low.
  assign w_bit_idx = step_q[5:1];
  assign w_pix_col = 4'd15 - w_bit_idx[3:0];
  assign w_pix     = data_q[{w_pix_col, 1'b0} +: 2];
  assign w_bit_val = w_bit_idx[4] ? (w_bit_idx[3:0] != row_q) : (w_pix > w_phase);

  // Scan sequencer: fetch row, shift 32 bits on ticks, latch, advance row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      div_q         <= 10'd0;
      step_q        <= 7'd0;
      latch_q       <= 1'b0;
      row_q         <= 4'd0;
      data_q        <= 32'd0;
      started_q     <= 1'b0;
      req_q         <= 1'b0;
      front_sel_q   <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      sclk_q        <= 1'b0;
      sdata_q       <= 1'b0;
      rclk_q        <= 1'b0;
      clear_q       <= 1'b0;
    end else begin
      clear_q       <= 1'b1;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
      div_q         <= w_tick ? 10'd0 : div_q + 10'd1;

      case (state_q)
        ST_FETCH: begin
          sclk_q <= 1'b0;
          rclk_q <= 1'b0;
          if (!started_q) begin
            // First fetch after reset opens a new frame
            started_q     <= 1'b1;
            req_q         <= 1'b1;
            frame_start_q <= 1'b1;
          end else if (req_q && pix_rd_ack) begin
            // Restart the divider so a long stall never shortens bit 0
            data_q  <= pix_rd_data;
            req_q   <= 1'b0;
            div_q   <= 10'd0;
            step_q  <= 7'd0;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_tick) begin
            if (step_q == C_STEP_LAST) begin
              sclk_q  <= 1'b0;
              rclk_q  <= 1'b1;
              latch_q <= 1'b0;
              state_q <= ST_LATCH;
            end else begin
              step_q <= step_q + 7'd1;
              if (!step_q[0]) begin
                sdata_q <= w_bit_val;
                sclk_q  <= 1'b0;
              end else begin
                sclk_q  <= 1'b1;
              end
            end
          end
        end

        ST_LATCH: begin
          if (w_tick) begin
            if (!latch_q) begin
              latch_q <= 1'b1;
            end else begin
              rclk_q  <= 1'b0;
              req_q   <= 1'b1;
              row_q   <= row_q + 4'd1;
              state_q <= ST_FETCH;
              if (w_frame_end) begin
                frame_start_q <= 1'b1;
                if (swap_req) begin
                  front_sel_q <= ~front_sel_q;
                  swap_ack_q  <= 1'b1;
                end
              end
            end
          end
        end

        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign pix_rd_req  = req_q;
  assign pix_rd_row  = row_q;
  assign pix_rd_sel  = front_sel_q;
  assign front_sel   = front_sel_q;
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign sclk        = sclk_q;
  assign serial_data = sdata_q;
  assign rclk        = rclk_q;
  assign clear       = clear_q;

endmodule
`default_nettype wire

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 100, clk cycles per sclk half-period; legal range 1..1023.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 pix_rd_req  output  1  frame-buffer row read request.
REQ-005 pix_rd_row  output  4  row address being fetched.
REQ-006 pix_rd_sel  output  1  buffer being read; always equals front_sel.
REQ-007 pix_rd_ack  input  1  read acknowledge; pix_rd_data valid in the same cycle.
REQ-008 pix_rd_data  input  32  16 pixels x 2 bit; pixel c at bits [2c+1:2c].
REQ-009 swap_req  input  1  level request from writer to exchange front/back buffers.
REQ-010 swap_ack  output  1  one-clk pulse; swap performed.
REQ-011 front_sel  output  1  currently displayed buffer.
REQ-012 frame_start  output  1  one-clk pulse at the start of each frame's first fetch.
REQ-013 sclk, serial_data, rclk  output  1 each  shift-register clock, data and latch.
REQ-014 clear  output  1  shift-register clear, active low.

Function
REQ-015 FSM states: FETCH, SHIFT, LATCH; FETCH follows reset.
REQ-016 A tick occurs every CLK_DIV clk cycles; all sclk, serial_data and rclk changes occur only on ticks.
REQ-017 FETCH: pix_rd_req=1 and pix_rd_row=row until pix_rd_ack sampled 1; data captured in that cycle; req=0 in the next cycle; sclk=0 and rclk=0 throughout; wait unbounded.
REQ-018 SHIFT: 32 bits; each bit lasts 2 ticks (sclk 0, then 1); serial_data is stable for the full bit.
REQ-019 Bits 0..15 are anode bits; bit i is 1 iff pixel (15-i) > phase.
REQ-020 Bits 16..31 are cathode bits; bit 16+k is 0 iff k == row, else 1.
REQ-021 LATCH: rclk=1 and sclk=0 for 2 ticks, then rclk=0; row advances to FETCH.
REQ-022 Row counts 0..15 and wraps; on wrap, phase counts 0..3 and wraps.
REQ-023 A frame is 64 row scans; frame_start pulses when the FETCH of row 0, phase 0 is entered.
REQ-024 Swap: if swap_req=1 when the LATCH of row 15, phase 3 completes, toggle front_sel and pulse swap_ack in that same cycle.
REQ-025 swap_req rising mid-frame waits for the frame boundary; swap_req dropped before the boundary cancels the swap.
REQ-026 Every swap_ack follows an observed swap_req=1; at most one swap per frame.
REQ-027 Ack arriving after a long stall does not shorten the following bit periods; the tick counter restarts on SHIFT entry.

Reset
REQ-028 While rst_n=0: pix_rd_req=0, pix_rd_row=0, front_sel=0, swap_ack=0, frame_start=0, sclk=0, serial_data=0, rclk=0, clear=0; row=0, phase=0, state=FETCH.
REQ-029 clear goes 1 on the first clk edge after rst_n deasserts and stays 1.
REQ-030 Reset mid-operation aborts any shift or fetch immediately; no rclk pulse is emitted.
REQ-031 frame_start pulses on the first fetch after reset.

Configuration
REQ-032 Macro MATRIX_GRAY_EN defined: 4-phase grayscale per REQ-019/REQ-022; a frame is 64 row scans.
REQ-033 MATRIX_GRAY_EN undefined: the phase counter is removed and phase is fixed at 0; anode bit is 1 iff pixel != 0; a frame is 16 row scans; swap is checked after the LATCH of row 15.

Verification
REQ-034 CLK_DIV=2, ack 3 cycles after req, pix_rd_data=32'h0000_0003 at row 0 -> anode bits 0..14=0 and bit 15=1, cathode bit 16=0 and others 1, each bit 4 clk long, rclk high 4 clk.
REQ-035 Gray build, all pixels=2 -> anode bits all 1 in phases 0,1 and all 0 in phases 2,3; frame_start period = 64 row scans.
REQ-036 swap_req raised during row 5 and held -> exactly one swap_ack at the end of row 15, phase 3; front_sel 0->1; pix_rd_sel follows.
REQ-037 swap_req pulsed for 10 clk during row 7 -> no swap_ack and front_sel unchanged.
REQ-038 pix_rd_ack withheld for 1000 clk -> sclk=0 and rclk=0 throughout; normal timing resumes after ack.
REQ-039 rst_n asserted mid-SHIFT at bit 20 -> all outputs reach reset values asynchronously; after release the first fetch is row 0 with a frame_start pulse.
